// File: rtl/pipeline_run_ctrl_pkg.sv
// Shared definitions for the pipeline run/step/halt sequencer:
// state encoding and the stage-enable bundle layout.
package pipeline_pkg;

  localparam int STATE_W          = 3;
  localparam int DRAIN_CYCLES_DEF = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

  // Bundle order, MSB first: PC, IF/ID, ID/EX, EX/MEM, MEM/WB.
  localparam int EN_PC     = 4;
  localparam int EN_IF_ID  = 3;
  localparam int EN_ID_EX  = 2;
  localparam int EN_EX_MEM = 1;
  localparam int EN_MEM_WB = 0;

  typedef logic [4:0] stage_en_t;

  localparam stage_en_t EN_NONE = 5'b00000;
  localparam stage_en_t EN_ALL  = 5'b11111;
  // Front end frozen, back end keeps advancing (stall, halt detect, drain).
  localparam stage_en_t EN_BACK = 5'b00111;

endpackage

// File: rtl/pipeline_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous reset.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_run_ctrl.sv
// Run/step/halt sequencer for the 5-stage pipeline: drives per-stage
// enables and the ID/EX bubble, and drains the pipe after a HALT decode.
module pipeline_run_ctrl
  import pipeline_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int CNT_W        = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_run,
  input  logic               cmd_step,
  input  logic               cmd_stop,
  input  logic               cmd_clear,
  input  logic               halt_detected,
  input  logic               load_use_hazard,
  output logic               pc_enable,
  output logic               if_id_enable,
  output logic               id_ex_enable,
  output logic               ex_mem_enable,
  output logic               mem_wb_enable,
  output logic               id_ex_flush,
  output logic [STATE_W-1:0] state,
  output logic               halted,
  output logic [CNT_W-1:0]   cycle_count
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_e        state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          halted_q;
  stage_en_t     en;
  logic          flush;
  logic          cnt_clr;

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    en      = EN_NONE;
    flush   = 1'b0;
    cnt_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_clear) begin
          cnt_clr = 1'b1;
        end else if (cmd_run) begin
          state_d = ST_RUN;
        end else if (cmd_step) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN, ST_STEP: begin
        en = EN_ALL;
        if (halt_detected) begin
          // Detect cycle already counts as the first back-end advance.
          en      = EN_BACK;
          flush   = 1'b1;
          state_d = ST_DRAIN;
          drain_d = DW'(DRAIN_CYCLES - 1);
        end else begin
          if (load_use_hazard) begin
            en    = EN_BACK;
            flush = 1'b1;
          end
          if ((state_q == ST_STEP) || cmd_stop) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        en    = EN_BACK;
        flush = 1'b1;
        if (drain_q == '0) begin
          state_d = ST_HALTED;
        end else begin
          drain_d = drain_q - DW'(1);
        end
      end
      ST_HALTED: begin
        if (cmd_clear) begin
          cnt_clr = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      drain_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      halted_q <= (state_d == ST_HALTED);
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk     (clk),
    .rst     (rst),
    .en_i    (mem_wb_enable),
    .clr_i   (cnt_clr),
    .count_o (cycle_count)
  );

  assign pc_enable     = en[EN_PC];
  assign if_id_enable  = en[EN_IF_ID];
  assign id_ex_enable  = en[EN_ID_EX];
  assign ex_mem_enable = en[EN_EX_MEM];
  assign mem_wb_enable = en[EN_MEM_WB];
  assign id_ex_flush   = flush;
  assign state         = state_q;
  assign halted        = halted_q;

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Directed bench for pipeline_run_ctrl: default instance plus a 4-bit
// counter instance for saturation.
module tb_pipeline_run_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_run = 0, cmd_step = 0, cmd_stop = 0, cmd_clear = 0;
  logic halt_detected = 0, load_use_hazard = 0;

  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, flush, halted;
  logic [2:0]  st;
  logic [31:0] count;
  logic [4:0]  ens;

  logic s_run = 0, s_step = 0, s_stop = 0, s_clear = 0, s_halt = 0, s_hz = 0;
  logic s_pc, s_ifid, s_idex, s_exmem, s_memwb, s_flush, s_halted;
  logic [2:0] s_st;
  logic [3:0] s_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign ens = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};

  pipeline_run_ctrl #(.DRAIN_CYCLES(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .cmd_run(cmd_run), .cmd_step(cmd_step), .cmd_stop(cmd_stop), .cmd_clear(cmd_clear),
    .halt_detected(halt_detected), .load_use_hazard(load_use_hazard),
    .pc_enable(pc_en), .if_id_enable(if_id_en), .id_ex_enable(id_ex_en),
    .ex_mem_enable(ex_mem_en), .mem_wb_enable(mem_wb_en), .id_ex_flush(flush),
    .state(st), .halted(halted), .cycle_count(count)
  );

  pipeline_run_ctrl #(.DRAIN_CYCLES(4), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst),
    .cmd_run(s_run), .cmd_step(s_step), .cmd_stop(s_stop), .cmd_clear(s_clear),
    .halt_detected(s_halt), .load_use_hazard(s_hz),
    .pc_enable(s_pc), .if_id_enable(s_ifid), .id_ex_enable(s_idex),
    .ex_mem_enable(s_exmem), .mem_wb_enable(s_memwb), .id_ex_flush(s_flush),
    .state(s_st), .halted(s_halted), .cycle_count(s_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset held, then released and idle for 5 cycles.
    tick();
    #1;
    chk("rst_ens", {27'd0, ens}, 32'h0);
    chk("rst_state", {29'd0, st}, 32'd0);
    chk("rst_count", count, 32'd0);
    tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("idle_ens", {27'd0, ens}, 32'h0);
    chk("idle_flush", {31'd0, flush}, 32'd0);
    chk("idle_state", {29'd0, st}, 32'd0);
    chk("idle_halted", {31'd0, halted}, 32'd0);
    chk("idle_count", count, 32'd0);

    // Asynchronous reset in the middle of RUN.
    cmd_run = 1; tick(); cmd_run = 0;
    chk("midrun_state", {29'd0, st}, 32'd1);
    tick(); tick();
    chk("midrun_count", count, 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ens", {27'd0, ens}, 32'h0);
    chk("async_rst_state", {29'd0, st}, 32'd0);
    chk("async_rst_count", count, 32'd0);
    tick();
    rst = 1'b0;

    // Run 10 cycles, stop on the 11th: 11 advancing cycles.
    cmd_run = 1; tick(); cmd_run = 0;
    for (int i = 0; i <= 10; i++) begin
      if (i == 10) cmd_stop = 1;
      #1;
      chk("run_ens", {27'd0, ens}, 32'h1f);
      tick();
    end
    cmd_stop = 0;
    chk("stop_state", {29'd0, st}, 32'd0);
    chk("stop_ens", {27'd0, ens}, 32'h0);
    chk("run_count", count, 32'd11);

    // clear beats run in the same IDLE cycle.
    cmd_clear = 1; cmd_run = 1; tick(); cmd_clear = 0; cmd_run = 0;
    chk("clr_prio_state", {29'd0, st}, 32'd0);
    chk("clr_prio_count", count, 32'd0);

    // Load-use stall for one RUN cycle.
    cmd_run = 1; tick(); cmd_run = 0;
    load_use_hazard = 1; #1;
    chk("hz_ens", {27'd0, ens}, 32'h07);
    chk("hz_flush", {31'd0, flush}, 32'd1);
    tick();
    load_use_hazard = 0; cmd_stop = 1; #1;
    chk("hz_after_ens", {27'd0, ens}, 32'h1f);
    chk("hz_after_flush", {31'd0, flush}, 32'd0);
    tick();
    cmd_stop = 0;
    chk("hz_count", count, 32'd2);

    // Three single steps separated by idle gaps.
    cmd_clear = 1; tick(); cmd_clear = 0;
    chk("clr_count", count, 32'd0);
    for (int k = 0; k < 3; k++) begin
      cmd_step = 1; tick(); cmd_step = 0; #1;
      chk("step_state", {29'd0, st}, 32'd2);
      chk("step_ens", {27'd0, ens}, 32'h1f);
      tick();
      chk("step_back_state", {29'd0, st}, 32'd0);
      chk("step_back_ens", {27'd0, ens}, 32'h0);
      chk("step_count", count, 32'(k + 1));
      repeat (2) tick();
    end

    // HALT in RUN: detect cycle + 4 drain cycles, then HALTED.
    cmd_clear = 1; tick(); cmd_clear = 0;
    cmd_run = 1; tick(); cmd_run = 0;
    repeat (3) tick();
    chk("pre_halt_count", count, 32'd3);
    halt_detected = 1; #1;
    chk("detect_ens", {27'd0, ens}, 32'h07);
    chk("detect_flush", {31'd0, flush}, 32'd1);
    chk("detect_state", {29'd0, st}, 32'd1);
    tick();
    halt_detected = 0;
    for (int d = 0; d < 4; d++) begin
      if (d == 1) begin cmd_stop = 1; load_use_hazard = 1; end
      #1;
      chk("drain_state", {29'd0, st}, 32'd3);
      chk("drain_ens", {27'd0, ens}, 32'h07);
      chk("drain_flush", {31'd0, flush}, 32'd1);
      chk("drain_halted", {31'd0, halted}, 32'd0);
      tick();
      cmd_stop = 0; load_use_hazard = 0;
    end
    chk("halted_state", {29'd0, st}, 32'd4);
    chk("halted_flag", {31'd0, halted}, 32'd1);
    chk("halted_ens", {27'd0, ens}, 32'h0);
    chk("halted_count", count, 32'd8);
    cmd_run = 1; tick(); cmd_run = 0;
    chk("halted_run_ign", {29'd0, st}, 32'd4);
    chk("halted_run_count", count, 32'd8);
    cmd_clear = 1; tick(); cmd_clear = 0;
    chk("halted_clr_state", {29'd0, st}, 32'd0);
    chk("halted_clr_count", count, 32'd0);
    chk("halted_clr_flag", {31'd0, halted}, 32'd0);

    // HALT seen during STEP also drains.
    cmd_step = 1; tick(); cmd_step = 0;
    halt_detected = 1; #1;
    chk("step_halt_ens", {27'd0, ens}, 32'h07);
    tick();
    halt_detected = 0;
    chk("step_halt_state", {29'd0, st}, 32'd3);
    repeat (4) tick();
    chk("step_halt_done", {29'd0, st}, 32'd4);
    chk("step_halt_count", count, 32'd5);
    cmd_clear = 1; tick(); cmd_clear = 0;

    // run+step together -> RUN; reset in the middle of DRAIN.
    cmd_run = 1; cmd_step = 1; tick(); cmd_run = 0; cmd_step = 0;
    chk("run_step_state", {29'd0, st}, 32'd1);
    halt_detected = 1; tick(); halt_detected = 0;
    chk("pre_rst_drain", {29'd0, st}, 32'd3);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("drain_rst_state", {29'd0, st}, 32'd0);
    chk("drain_rst_halted", {31'd0, halted}, 32'd0);
    chk("drain_rst_count", count, 32'd0);
    chk("drain_rst_ens", {27'd0, ens}, 32'h0);
    tick();
    rst = 1'b0;
    repeat (2) tick();
    chk("post_rst_state", {29'd0, st}, 32'd0);

    // 4-bit counter saturates at 15.
    s_run = 1; tick(); s_run = 0;
    repeat (14) tick();
    chk("sat_14", {28'd0, s_count}, 32'd14);
    tick();
    chk("sat_15", {28'd0, s_count}, 32'd15);
    repeat (5) tick();
    chk("sat_hold", {28'd0, s_count}, 32'd15);
    chk("sat_state", {29'd0, s_st}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_run_ctrl.md
Name: pipeline_run_ctrl

Overview:
- Run/step/halt sequencer for the 5-stage MIPS pipeline.
- Drives the per-stage `enable` inputs (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) and the ID/EX bubble insert, so the execute stage and its EX/MEM register advance only when sequenced.
- Accepts run/step/stop/clear commands from the debug unit, inserts a load-use stall on request, and drains in-flight instructions after a HALT decode before reporting halted.

Parameters:
- DRAIN_CYCLES, 4, cycles the pipeline keeps advancing after HALT is detected in IF/ID before entering HALTED (min 1).
- CNT_W, 32, width of the executed-cycle counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- cmd_run  input  1  one-cycle pulse: free-run.
- cmd_step  input  1  one-cycle pulse: advance exactly one cycle.
- cmd_stop  input  1  one-cycle pulse: pause free-run.
- cmd_clear  input  1  one-cycle pulse: return to IDLE and zero the counter.
- halt_detected  input  1  HALT opcode present in IF/ID this cycle.
- load_use_hazard  input  1  hazard unit requests a one-cycle stall.
- pc_enable  output  1  PC register enable.
- if_id_enable  output  1  IF/ID register enable.
- id_ex_enable  output  1  ID/EX register enable.
- ex_mem_enable  output  1  EX/MEM register enable.
- mem_wb_enable  output  1  MEM/WB register enable.
- id_ex_flush  output  1  load zero control word (bubble) into ID/EX.
- state  output  3  current FSM state encoding.
- halted  output  1  high in HALTED.
- cycle_count  output  CNT_W  number of cycles in which MEM/WB advanced.

Behaviour:
- State encoding: IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4. `state`, `halted`, `cycle_count` and the drain counter are registers.
- Stage enables and `id_ex_flush` are combinational from state and inputs.
- Reset (asynchronous, any time, including mid-DRAIN or mid-STEP):
  - state=IDLE, cycle_count=0, drain counter=0.
  - All enables=0, id_ex_flush=0, halted=0, state output=0.
- IDLE: all enables 0, flush 0. Transitions, highest priority first:
  - cmd_clear: zero the counter, stay IDLE.
  - cmd_run: go to RUN.
  - cmd_step: go to STEP.
  - cmd_stop: ignored.
- RUN and STEP ("advance" states): all five enables 1, flush 0, with these overrides:
  - load_use_hazard=1: pc_enable=0, if_id_enable=0, id_ex_flush=1. Downstream enables stay 1.
  - halt_detected=1: pc_enable=0, if_id_enable=0, id_ex_flush=1. Go to DRAIN and load the drain counter with DRAIN_CYCLES-1.
  - halt_detected takes precedence over load_use_hazard; the outputs are identical either way.
- RUN transitions:
  - halt_detected: go to DRAIN.
  - Otherwise cmd_stop: go to IDLE. The stop cycle itself still advances.
  - cmd_run, cmd_step, cmd_clear: ignored.
- STEP lasts exactly one cycle. It goes to DRAIN if halt_detected, otherwise to IDLE. All commands are ignored.
- DRAIN:
  - Outputs: pc_enable=0, if_id_enable=0, id_ex_flush=1, id_ex/ex_mem/mem_wb enables 1.
  - The drain counter decrements each cycle; when it reads 0, go to HALTED.
  - DRAIN therefore lasts DRAIN_CYCLES cycles after the detect cycle.
  - All commands and both hazard inputs are ignored.
- HALTED: all enables 0, halted=1. cmd_clear goes to IDLE and zeroes the counter; all other commands are ignored.
- cycle_count:
  - Increments by 1 on each clock edge where mem_wb_enable=1 (RUN, STEP, DRAIN, including the detect cycle).
  - Saturates at all-ones; no wrap.
  - cmd_clear in IDLE or HALTED takes priority over an increment; none occurs in those states anyway.
- Simultaneous commands in IDLE resolve by the priority order clear > run > step.
- Illegal state encodings (5–7) return to IDLE on the next edge, with all enables 0.

Decomposition:
- Shared package `pipeline_pkg`:
  - state localparams ST_IDLE..ST_HALTED and STATE_W=3;
  - DRAIN_CYCLES default constant;
  - stage-enable bundle ordering (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- One natural sub-module: `sat_counter` (CNT_W-bit, enable, synchronous clear, saturate, async reset), used for cycle_count.
- FSM and enable decode stay in pipeline_run_ctrl.

Test Plan:
- Reset then idle 5 cycles -> all enables 0, state=0, cycle_count=0. Assert rst mid-RUN -> same values immediately, before the next clock edge.
- cmd_run, 10 cycles, then cmd_stop -> enables 1 for 11 cycles, state=0 afterward, cycle_count=11.
- In RUN, pulse load_use_hazard for 1 cycle -> that cycle pc_enable=0, if_id_enable=0, id_ex_flush=1, ex_mem_enable=1; cycle_count still increments.
- Three cmd_step pulses separated by idle gaps -> each yields exactly one cycle with all enables 1; cycle_count=3; state back to 0 after each.
- In RUN, assert halt_detected at cycle N with DRAIN_CYCLES=4 -> detect cycle plus 4 DRAIN cycles with pc_enable=0 and flush=1, then halted=1, state=4, and cycle_count grew by 5. cmd_run in HALTED is ignored; cmd_clear gives state=0 and cycle_count=0.
- cmd_run and cmd_step in the same IDLE cycle -> RUN. Assert rst during DRAIN -> IDLE, halted=0, cycle_count=0. With CNT_W=4, run 20 cycles -> cycle_count holds at 15.
